// File: rtl/circle_anim_ctrl.sv
// Run/pause/step sequencer for the walking-circle animation: owns the tick
// timebase, its speed scaling, and the lap counter with optional auto-stop.
module circle_anim_ctrl #(
  parameter int NUM_OF_DISPLAYS = 6,
  parameter int COL_WIDTH       = $clog2(NUM_OF_DISPLAYS),
  parameter int BASE_DIV        = 50000000,
  parameter int MAX_SPEED       = 4,
  parameter int DEFAULT_SPEED   = 1,
  parameter int LAP_W           = 8,
  parameter int LAP_TARGET      = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 step_i,
  input  logic                 speed_up_i,
  input  logic                 speed_down_i,
  input  logic [COL_WIDTH-1:0] pos_i,
  input  logic                 dir_i,
  output logic                 tick_o,
  output logic [1:0]           state_o,
  output logic [2:0]           speed_o,
  output logic [LAP_W-1:0]     lap_cnt_o,
  output logic                 done_o
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_STEP  = 2'b11;

  localparam logic [2:0]       SPEED_MAX  = 3'(MAX_SPEED);
  localparam logic [2:0]       SPEED_RST  = 3'(DEFAULT_SPEED);
  localparam logic [LAP_W-1:0] LAP_MAX    = '1;
  localparam logic [LAP_W-1:0] LAP_GOAL   = LAP_W'(LAP_TARGET);
  localparam bit               AUTO_STOP  = (LAP_TARGET != 0);

  typedef struct packed {
    logic start;
    logic stop;
    logic step;
  } cmd_t;

  logic [1:0]       state_q, state_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic [2:0]       speed_q, speed_d;
  logic [LAP_W-1:0] lap_q, lap_d;
  logic             done_q, done_d;

  cmd_t        cmd;
  logic [31:0] period;
  logic        lap_hit;

  // Priority encode the buttons: stop beats start beats step.
  always_comb begin
    cmd.stop  = stop_i;
    cmd.start = start_i & ~stop_i;
    cmd.step  = step_i & ~stop_i & ~start_i;
  end

  always_comb begin
    period = 32'(BASE_DIV) >> speed_q;
    if (period == 32'd0) period = 32'd1;
  end

  always_comb begin
    speed_d = speed_q;
    if (speed_up_i && !speed_down_i && speed_q < SPEED_MAX)
      speed_d = speed_q + 3'd1;
    else if (speed_down_i && !speed_up_i && speed_q != 3'd0)
      speed_d = speed_q - 3'd1;
  end

  // The animation reaches the left end heading left once per full circuit.
  assign lap_hit = tick_q && !dir_i && (pos_i == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    lap_d   = lap_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd.start) begin
          state_d = S_RUN;
          lap_d   = '0;
        end else if (cmd.step) begin
          state_d = S_STEP;
        end
      end
      S_RUN:   if (cmd.stop) state_d = S_PAUSE;
      S_PAUSE: begin
        if (cmd.start)     state_d = S_RUN;
        else if (cmd.step) state_d = S_STEP;
      end
      S_STEP:  state_d = S_PAUSE;
      default: state_d = S_IDLE;
    endcase

    if (lap_hit && lap_q != LAP_MAX) begin
      lap_d = lap_q + LAP_W'(1);
      if (AUTO_STOP && lap_d == LAP_GOAL) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end

    // The prescaler only advances while staying in RUN, so the cycle that
    // leaves RUN freezes cnt and can never emit a tick into PAUSE or IDLE.
    if (state_d == S_IDLE) begin
      cnt_d = '0;
    end else if (state_q == S_RUN && state_d == S_RUN) begin
      if (cnt_q >= period - 32'd1) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end

    if (state_d == S_STEP) tick_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      speed_q <= SPEED_RST;
      lap_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      speed_q <= speed_d;
      lap_q   <= lap_d;
      done_q  <= done_d;
    end
  end

  assign tick_o    = tick_q;
  assign state_o   = state_q;
  assign speed_o   = speed_q;
  assign lap_cnt_o = lap_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_circle_anim_ctrl.sv
// Scoreboard bench for circle_anim_ctrl: stimulus pushes expected values tagged
// with the clock edge they belong to; a monitor compares them each cycle.
module tb_circle_anim_ctrl;

  localparam logic [4:0] C_START = 5'b10000;
  localparam logic [4:0] C_STOP  = 5'b01000;
  localparam logic [4:0] C_STEP  = 5'b00100;
  localparam logic [4:0] C_UP    = 5'b00010;
  localparam logic [4:0] C_DN    = 5'b00001;

  localparam int SG_STATE = 0;
  localparam int SG_SPEED = 1;
  localparam int SG_LAP   = 2;
  localparam int SG_DONE  = 3;

  typedef struct {
    int e;
    int sig;
    int val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       start_i, stop_i, step_i, speed_up_i, speed_down_i;
  logic [2:0] pos_i;
  logic       dir_i;
  logic       tick_o;
  logic [1:0] state_o;
  logic [2:0] speed_o;
  logic [7:0] lap_cnt_o;
  logic       done_o;

  int   ecnt   = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   tick_q[$];
  int   done_q[$];

  circle_anim_ctrl #(
    .NUM_OF_DISPLAYS(6),
    .BASE_DIV(8),
    .MAX_SPEED(2),
    .DEFAULT_SPEED(0),
    .LAP_W(8),
    .LAP_TARGET(2)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .start_i(start_i),
    .stop_i(stop_i),
    .step_i(step_i),
    .speed_up_i(speed_up_i),
    .speed_down_i(speed_down_i),
    .pos_i(pos_i),
    .dir_i(dir_i),
    .tick_o(tick_o),
    .state_o(state_o),
    .speed_o(speed_o),
    .lap_cnt_o(lap_cnt_o),
    .done_o(done_o)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    ecnt++;
  end

  function automatic string sig_name(input int s);
    case (s)
      SG_STATE: return "state_o";
      SG_SPEED: return "speed_o";
      SG_LAP:   return "lap_cnt_o";
      default:  return "done_o";
    endcase
  endfunction

  function automatic int sig_val(input int s);
    case (s)
      SG_STATE: return int'(state_o);
      SG_SPEED: return int'(speed_o);
      SG_LAP:   return int'(lap_cnt_o);
      default:  return int'(done_o);
    endcase
  endfunction

  task automatic expv(input int dly, input int s, input int v);
    exp_t x;
    x.e = ecnt + dly; x.sig = s; x.val = v;
    exp_q.push_back(x);
  endtask

  task automatic exp_tick(input int dly);
    tick_q.push_back(ecnt + dly);
  endtask

  task automatic exp_done(input int dly);
    done_q.push_back(ecnt + dly);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic cmd(input logic [4:0] c);
    {start_i, stop_i, step_i, speed_up_i, speed_down_i} = c;
    @(posedge clk); #1;
    {start_i, stop_i, step_i, speed_up_i, speed_down_i} = 5'b0;
  endtask

  // Monitor: outputs sampled on the falling edge, half a cycle after update.
  initial begin
    int act;
    bit found;
    forever begin
      @(negedge clk);
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].e <= ecnt) begin
          checks++;
          act = sig_val(exp_q[i].sig);
          if (exp_q[i].e < ecnt) begin
            errors++;
            $display("FAIL %s never sampled for edge %0d", sig_name(exp_q[i].sig), exp_q[i].e);
          end else if (act != exp_q[i].val) begin
            errors++;
            $display("FAIL %s edge %0d actual %0d required %0d",
                     sig_name(exp_q[i].sig), ecnt, act, exp_q[i].val);
          end
          exp_q.delete(i);
        end
      end

      found = 1'b0;
      for (int i = tick_q.size() - 1; i >= 0; i--) begin
        if (tick_q[i] == ecnt) begin
          found = 1'b1;
          tick_q.delete(i);
        end
      end
      if (found || tick_o === 1'b1) begin
        checks++;
        if (found && tick_o !== 1'b1) begin
          errors++;
          $display("FAIL tick_o edge %0d actual %b required 1", ecnt, tick_o);
        end else if (!found) begin
          errors++;
          $display("FAIL tick_o edge %0d actual 1 required 0 (unexpected tick)", ecnt);
        end
      end

      found = 1'b0;
      for (int i = done_q.size() - 1; i >= 0; i--) begin
        if (done_q[i] == ecnt) begin
          found = 1'b1;
          done_q.delete(i);
        end
      end
      if (found || done_o === 1'b1) begin
        checks++;
        if (found && done_o !== 1'b1) begin
          errors++;
          $display("FAIL done_o pulse edge %0d actual %b required 1", ecnt, done_o);
        end else if (!found) begin
          errors++;
          $display("FAIL done_o pulse edge %0d actual 1 required 0 (unexpected)", ecnt);
        end
      end
    end
  end

  initial begin
    rst_i = 1'b1;
    {start_i, stop_i, step_i, speed_up_i, speed_down_i} = 5'b0;
    pos_i = 3'd1;
    dir_i = 1'b1;

    // Reset values; no tick before start.
    repeat (2) @(posedge clk);
    #1;
    expv(0, SG_STATE, 0); expv(0, SG_SPEED, 0); expv(0, SG_LAP, 0); expv(0, SG_DONE, 0);
    rst_i = 1'b0;
    idle(3);
    expv(0, SG_STATE, 0);

    // Free run: one tick every 8 cycles.
    cmd(C_START);
    expv(0, SG_STATE, 1);
    exp_tick(8); exp_tick(16); exp_tick(24);
    idle(24);

    // Pause after 3 RUN cycles (cnt=3), hold 20, resume: tick 5 cycles later.
    idle(3);
    cmd(C_STOP);
    expv(0, SG_STATE, 2);
    idle(20);
    expv(0, SG_STATE, 2);
    cmd(C_START);
    expv(0, SG_STATE, 1);
    exp_tick(5); exp_tick(13);
    idle(13);

    // Single step from PAUSE.
    cmd(C_STOP);
    expv(0, SG_STATE, 2);
    idle(2);
    cmd(C_STEP);
    expv(0, SG_STATE, 3); exp_tick(0); expv(1, SG_STATE, 2);
    idle(4);

    // Speed saturation and simultaneous up/down.
    cmd(C_UP);        expv(0, SG_SPEED, 1);
    cmd(C_UP);        expv(0, SG_SPEED, 2);
    cmd(C_UP);        expv(0, SG_SPEED, 2);
    cmd(C_UP | C_DN); expv(0, SG_SPEED, 2);
    cmd(C_START);
    exp_tick(2); exp_tick(4); exp_tick(6);
    idle(6);
    cmd(C_STOP);
    expv(0, SG_STATE, 2);
    cmd(C_DN); expv(0, SG_SPEED, 1);
    cmd(C_DN); expv(0, SG_SPEED, 0);
    cmd(C_DN); expv(0, SG_SPEED, 0);

    // Laps: a stepped tick and a run tick at the left end reach the target of 2.
    pos_i = 3'd0;
    dir_i = 1'b0;
    cmd(C_STEP);
    exp_tick(0); expv(1, SG_LAP, 1); expv(1, SG_STATE, 2);
    idle(3);
    cmd(C_START);
    exp_tick(8);
    exp_done(9); expv(9, SG_LAP, 2); expv(9, SG_STATE, 0);
    expv(10, SG_DONE, 0); expv(14, SG_STATE, 0); expv(14, SG_LAP, 2);
    idle(14);
    pos_i = 3'd1;
    dir_i = 1'b1;

    // Restart clears laps; step ignored in RUN; start+stop together pauses.
    cmd(C_START);
    expv(0, SG_STATE, 1); expv(0, SG_LAP, 0);
    idle(1);
    cmd(C_STEP);
    expv(0, SG_STATE, 1);
    idle(1);
    cmd(C_START | C_STOP);
    expv(0, SG_STATE, 2);

    // Shrink period below cnt+1 while paused (cnt=3, period 2): tick on first RUN cycle.
    cmd(C_UP);
    cmd(C_UP);
    expv(0, SG_SPEED, 2);
    cmd(C_START);
    exp_tick(1);
    idle(1);

    // Reset mid-RUN: reset values next cycle, no spurious tick.
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    expv(0, SG_STATE, 0); expv(0, SG_SPEED, 0); expv(0, SG_LAP, 0); expv(0, SG_DONE, 0);
    idle(5);
    expv(0, SG_STATE, 0);
    idle(2);
    #6;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
